avalon_mm_arbiter: RTL and testbench

- Shares one AvalonMmRw agent (memory/peripheral bus) between two hosts: host 0 is the instruction-fetch port and host 1 is the load/store MemoryUnit port.
- Grants one complete transaction at a time and holds that grant until the agent completes.
- Alternates priority round-robin, with an optional fixed-priority mode.
- Provides an optional watchdog that terminates transactions the agent never completes.

---
 rtl/avalon_mm_arbiter_pkg.sv | 16 +
 rtl/avalon_mm_arbiter_arb_pick.sv | 23 ++
 rtl/avalon_mm_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_avalon_mm_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the two-host Avalon-MM arbiter.
package avalon_mm_arbiter_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

  typedef bit host_id_t;

  localparam host_id_t HOST_FETCH = 1'b0;
  localparam host_id_t HOST_DATA  = 1'b1;

  // A host asserting both strobes, or neither, is not asking for the bus.
  function automatic logic is_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_arb_pick.sv
// Combinational grant selection between the fetch and data hosts.
module avalon_mm_arbiter_arb_pick
  import avalon_mm_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       round_robin,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = HOST_FETCH;
    unique case (req)
      2'b01:   grant_id = HOST_FETCH;
      2'b10:   grant_id = HOST_DATA;
      2'b11:   grant_id = round_robin ? ~last : HOST_DATA;
      default: grant_id = HOST_FETCH;
    endcase
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Two-host Avalon-MM arbiter: one whole transaction per grant, round-robin or
// fixed priority, optional watchdog that terminates stuck transactions.
module avalon_mm_arbiter
  import avalon_mm_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_W      = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  fetch_read,
  input  logic                  fetch_write,
  input  logic [ADDR_W-1:0]     fetch_address,
  input  logic [DATA_W/8-1:0]   fetch_byteenable,
  input  logic [DATA_W-1:0]     fetch_host_to_agent,
  output logic                  fetch_waitrequest,
  output logic                  fetch_readdatavalid,
  output logic [DATA_W-1:0]     fetch_agent_to_host,

  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_W-1:0]     data_address,
  input  logic [DATA_W/8-1:0]   data_byteenable,
  input  logic [DATA_W-1:0]     data_host_to_agent,
  output logic                  data_waitrequest,
  output logic                  data_readdatavalid,
  output logic [DATA_W-1:0]     data_agent_to_host,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_host_to_agent,
  input  logic                  mem_waitrequest,
  input  logic                  mem_readdatavalid,
  input  logic [DATA_W-1:0]     mem_agent_to_host,

  output logic                  owner,
  output logic                  busy,
  output logic                  bus_error
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t           state, state_nxt;
  host_id_t             owner_q, owner_nxt;
  host_id_t             last_q, last_nxt;
  logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
  logic                 bus_error_q, bus_error_nxt;

  logic [1:0] req;
  logic       grant_valid, grant_id;
  logic       in_busy, sel_data;
  logic       own_read, own_write, own_req;
  logic       done, wdog_hit, expire;
  logic       rsp_wait, rsp_rdv;
  logic [DATA_W-1:0] rsp_data;

  assign req[0] = is_req(fetch_read, fetch_write);
  assign req[1] = is_req(data_read, data_write);

  avalon_mm_arbiter_arb_pick u_pick (
    .req         (req),
    .last        (last_q),
    .round_robin (ROUND_ROBIN != 0),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign in_busy   = (state == ARB_BUSY);
  assign sel_data  = in_busy && (owner_q == HOST_DATA);
  assign own_read  = (owner_q == HOST_DATA) ? data_read  : fetch_read;
  assign own_write = (owner_q == HOST_DATA) ? data_write : fetch_write;
  assign own_req   = req[owner_q];

  assign done = in_busy && own_req &&
                ((own_read && mem_readdatavalid && !mem_waitrequest) ||
                 (own_write && !mem_waitrequest));

  // wdog_hit depends only on registered state, so the waitrequest override
  // below never creates a path from a host's strobes to its own waitrequest.
  assign wdog_hit = WDOG_EN && in_busy && (wdog == WDOG_LAST);
  assign expire   = wdog_hit && !done;

  // Downstream forwarding; address/data fall back to host 0 when idle.
  assign mem_read          = in_busy && own_req && own_read  && !expire;
  assign mem_write         = in_busy && own_req && own_write && !expire;
  assign mem_address       = sel_data ? data_address       : fetch_address;
  assign mem_byteenable    = sel_data ? data_byteenable    : fetch_byteenable;
  assign mem_host_to_agent = sel_data ? data_host_to_agent : fetch_host_to_agent;

  // A completion implies waitrequest=0 already, so zeroing it on wdog_hit
  // leaves a completing transaction's response untouched.
  assign rsp_wait = wdog_hit ? 1'b0 : mem_waitrequest;
  assign rsp_rdv  = expire   ? 1'b1 : mem_readdatavalid;
  assign rsp_data = expire   ? '0   : mem_agent_to_host;

  always_comb begin
    fetch_waitrequest   = 1'b1;
    fetch_readdatavalid = 1'b0;
    fetch_agent_to_host = '0;
    data_waitrequest    = 1'b1;
    data_readdatavalid  = 1'b0;
    data_agent_to_host  = '0;
    if (in_busy) begin
      if (owner_q == HOST_DATA) begin
        data_waitrequest    = rsp_wait;
        data_readdatavalid  = rsp_rdv;
        data_agent_to_host  = rsp_data;
      end else begin
        fetch_waitrequest   = rsp_wait;
        fetch_readdatavalid = rsp_rdv;
        fetch_agent_to_host = rsp_data;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner_q;
    last_nxt      = last_q;
    wdog_nxt      = wdog;
    bus_error_nxt = bus_error_q;
    unique case (state)
      ARB_IDLE: begin
        wdog_nxt = '0;
        if (grant_valid) begin
          state_nxt = ARB_BUSY;
          owner_nxt = grant_id;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_nxt = ARB_IDLE;
          last_nxt  = owner_q;
          wdog_nxt  = '0;
        end else if (expire) begin
          state_nxt     = ARB_IDLE;
          last_nxt      = owner_q;
          wdog_nxt      = '0;
          bus_error_nxt = 1'b1;
        end else if (!own_req) begin
          state_nxt = ARB_IDLE;
          wdog_nxt  = '0;
        end else begin
          wdog_nxt = WDOG_EN ? wdog + TIMEOUT_W'(1) : '0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // last resets to host 1 so host 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      owner_q     <= HOST_FETCH;
      last_q      <= HOST_DATA;
      wdog        <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner_q     <= owner_nxt;
      last_q      <= last_nxt;
      wdog        <= wdog_nxt;
      bus_error_q <= bus_error_nxt;
    end
  end

  assign owner     = owner_q;
  assign busy      = in_busy;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench: a round-robin arbiter with watchdog and a fixed-priority twin
// share the host stimulus; each has its own fixed-latency agent model.
module tb_avalon_mm_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        f_rd, f_wr, d_rd, d_wr;
  logic [31:0] f_addr, d_addr, f_wd, d_wd;
  logic [3:0]  f_be, d_be;

  logic        ag_en;
  logic [31:0] ag_data;
  int          cnt_a = 0;
  int          cnt_b = 0;

  logic        fa_wait, fa_rdv, da_wait, da_rdv, ma_rd, ma_wr;
  logic [31:0] fa_rdata, da_rdata, ma_addr, ma_wd;
  logic [3:0]  ma_be;
  logic        ma_wait, ma_rdv, owner_a, busy_a, berr_a;

  logic        fb_wait, fb_rdv, db_wait, db_rdv, mb_rd, mb_wr;
  logic [31:0] fb_rdata, db_rdata, mb_addr, mb_wd;
  logic [3:0]  mb_be;
  logic        mb_wait, mb_rdv, owner_b, busy_b, berr_b;

  int n_chk = 0;
  int n_err = 0;

  // Agent: answers on the LAT-th consecutive cycle a strobe is held.
  always @(posedge clk) begin
    if ((ma_rd || ma_wr) && cnt_a != LAT-1) cnt_a <= cnt_a + 1;
    else cnt_a <= 0;
    if ((mb_rd || mb_wr) && cnt_b != LAT-1) cnt_b <= cnt_b + 1;
    else cnt_b <= 0;
  end
  assign ma_wait = !(ag_en && cnt_a == LAT-1);
  assign ma_rdv  =  (ag_en && cnt_a == LAT-1);
  assign mb_wait = !(ag_en && cnt_b == LAT-1);
  assign mb_rdv  =  (ag_en && cnt_b == LAT-1);

  avalon_mm_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst(rst),
    .fetch_read(f_rd), .fetch_write(f_wr), .fetch_address(f_addr),
    .fetch_byteenable(f_be), .fetch_host_to_agent(f_wd),
    .fetch_waitrequest(fa_wait), .fetch_readdatavalid(fa_rdv),
    .fetch_agent_to_host(fa_rdata),
    .data_read(d_rd), .data_write(d_wr), .data_address(d_addr),
    .data_byteenable(d_be), .data_host_to_agent(d_wd),
    .data_waitrequest(da_wait), .data_readdatavalid(da_rdv),
    .data_agent_to_host(da_rdata),
    .mem_read(ma_rd), .mem_write(ma_wr), .mem_address(ma_addr),
    .mem_byteenable(ma_be), .mem_host_to_agent(ma_wd),
    .mem_waitrequest(ma_wait), .mem_readdatavalid(ma_rdv),
    .mem_agent_to_host(ag_data),
    .owner(owner_a), .busy(busy_a), .bus_error(berr_a)
  );

  avalon_mm_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .rst(rst),
    .fetch_read(f_rd), .fetch_write(f_wr), .fetch_address(f_addr),
    .fetch_byteenable(f_be), .fetch_host_to_agent(f_wd),
    .fetch_waitrequest(fb_wait), .fetch_readdatavalid(fb_rdv),
    .fetch_agent_to_host(fb_rdata),
    .data_read(d_rd), .data_write(d_wr), .data_address(d_addr),
    .data_byteenable(d_be), .data_host_to_agent(d_wd),
    .data_waitrequest(db_wait), .data_readdatavalid(db_rdv),
    .data_agent_to_host(db_rdata),
    .mem_read(mb_rd), .mem_write(mb_wr), .mem_address(mb_addr),
    .mem_byteenable(mb_be), .mem_host_to_agent(mb_wd),
    .mem_waitrequest(mb_wait), .mem_readdatavalid(mb_rdv),
    .mem_agent_to_host(ag_data),
    .owner(owner_b), .busy(busy_b), .bus_error(berr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt, acc;
    logic dw_ok;

    rst = 1'b0;
    f_rd = 0; f_wr = 0; f_addr = '0; f_be = 4'hF; f_wd = '0;
    d_rd = 0; d_wr = 0; d_addr = '0; d_be = 4'hF; d_wd = '0;
    ag_en = 1'b1; ag_data = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_owner", 32'(owner_a), 32'd0);
    check("rst_berr",  32'(berr_a),  32'd0);
    check("rst_mrd",   32'(ma_rd),   32'd0);
    check("rst_fwait", 32'(fa_wait), 32'd1);
    check("rst_dwait", 32'(da_wait), 32'd1);
    check("rst_frdv",  32'(fa_rdv),  32'd0);
    next_cycle();
    rst = 1'b1;

    // Single fetch read, completes on second BUSY cycle
    busy_cnt = 0; acc = 0; dw_ok = 1'b1;
    f_addr = 32'h40;
    for (int k = 0; k < 5; k++) begin
      f_rd = (k <= 2);
      @(negedge clk);
      busy_cnt += int'(busy_a);
      if (!fa_wait) begin
        acc++;
        check("t1_rdata", fa_rdata, 32'hDEADBEEF);
      end
      if (!da_wait) dw_ok = 1'b0;
      if (k == 0) check("t1_idle_mrd", 32'(ma_rd), 32'd0);
      if (k == 1) begin
        check("t1_mrd",   32'(ma_rd), 32'd1);
        check("t1_maddr", ma_addr,    32'h40);
        check("t1_owner", 32'(owner_a), 32'd0);
      end
      next_cycle();
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd2);
    check("t1_accepts",     32'(acc),      32'd1);
    check("t1_data_held",   32'(dw_ok),    32'd1);

    // Both hosts reading continuously from reset
    rst = 1'b0; f_rd = 1; d_rd = 1; d_addr = 32'h200;
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t2_rr_busy", 32'(busy_a), 32'((k % 3) != 0));
      if ((k % 3) != 0) check("t2_rr_owner", 32'(owner_a), 32'((k / 3) % 2));
      check("t3_fp_busy", 32'(busy_b), 32'((k % 3) != 0));
      if ((k % 3) != 0) check("t3_fp_owner", 32'(owner_b), 32'd1);
      next_cycle();
    end

    // Data write while fetch holds a read
    rst = 1'b0; f_rd = 0; d_rd = 0;
    next_cycle();
    rst = 1'b1;
    d_wr = 1; d_addr = 32'h100; d_be = 4'b0011; d_wd = 32'hCAFE0001;
    @(negedge clk);
    check("t4_k0_busy", 32'(busy_a), 32'd0);
    next_cycle();
    f_rd = 1; f_addr = 32'h80;
    @(negedge clk);
    check("t4_mwr",   32'(ma_wr),   32'd1);
    check("t4_mrd",   32'(ma_rd),   32'd0);
    check("t4_maddr", ma_addr,      32'h100);
    check("t4_mbe",   32'(ma_be),   32'h3);
    check("t4_mwd",   ma_wd,        32'hCAFE0001);
    check("t4_owner", 32'(owner_a), 32'd1);
    check("t4_fwait", 32'(fa_wait), 32'd1);
    check("t4_dwait", 32'(da_wait), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t4_done_dwait", 32'(da_wait), 32'd0);
    check("t4_done_fwait", 32'(fa_wait), 32'd1);
    next_cycle();
    d_wr = 0;
    @(negedge clk);
    check("t4_gap_busy", 32'(busy_a), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t4_f_busy",  32'(busy_a),  32'd1);
    check("t4_f_owner", 32'(owner_a), 32'd0);
    check("t4_f_maddr", ma_addr,      32'h80);
    next_cycle();
    @(negedge clk);
    check("t4_f_done", 32'(fa_wait), 32'd0);
    next_cycle();
    f_rd = 0;
    @(negedge clk);
    next_cycle();

    // Watchdog: agent never answers
    ag_en = 1'b0; f_rd = 1; f_addr = 32'h44;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t5_busy", 32'(busy_a), 32'(k >= 1));
      if (k >= 1 && k <= 7) check("t5_hold", {30'd0, fa_wait, fa_rdv}, 32'b10);
      if (k == 8) begin
        check("t5_exp_wait", 32'(fa_wait), 32'd0);
        check("t5_exp_rdv",  32'(fa_rdv),  32'd1);
        check("t5_exp_data", fa_rdata,     32'd0);
        check("t5_exp_mrd",  32'(ma_rd),   32'd0);
        check("t5_exp_berr", 32'(berr_a),  32'd0);
      end
      next_cycle();
    end
    f_rd = 0; d_wr = 1; d_addr = 32'h104; ag_en = 1'b1;
    @(negedge clk);
    check("t5_post_busy", 32'(busy_a), 32'd0);
    check("t5_post_berr", 32'(berr_a), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t5_next_busy",  32'(busy_a),  32'd1);
    check("t5_next_owner", 32'(owner_a), 32'd1);
    check("t5_next_mwr",   32'(ma_wr),   32'd1);
    next_cycle();
    @(negedge clk);
    check("t5_next_done", 32'(da_wait), 32'd0);
    next_cycle();
    d_wr = 0;
    @(negedge clk);
    check("t5_sticky", 32'(berr_a), 32'd1);
    next_cycle();

    // Asynchronous reset in the middle of a read
    f_rd = 1; f_addr = 32'h48;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("t6_pre_mrd",  32'(ma_rd),  32'd1);
    check("t6_pre_busy", 32'(busy_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_mrd",   32'(ma_rd),   32'd0);
    check("t6_busy",  32'(busy_a),  32'd0);
    check("t6_berr",  32'(berr_a),  32'd0);
    d_rd = 1;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("t6_k0_busy", 32'(busy_a), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_k1_busy",  32'(busy_a),  32'd1);
    check("t6_k1_owner", 32'(owner_a), 32'd0);
    next_cycle();
    f_rd = 0; d_rd = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
